// File: rtl/mem_loader_if.sv
// Loader bus: UART byte input, load control/status and the memory write port.
interface mem_loader_if #(
  parameter int B = 16,
  parameter int W = 11
);
  logic         start;
  logic [7:0]   rx_data;
  logic         rx_done;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] addr;
  logic [B-1:0] w_data;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    input  start, rx_data, rx_done,
    output wr_en, rd_en, addr, w_data, busy, done, err
  );

  modport slave (
    output start, rx_data, rx_done,
    input  wr_en, rd_en, addr, w_data, busy, done, err
  );
endinterface

// File: rtl/mem_loader.sv
// Byte-stream memory loader: 16-bit big-endian word-count header, then
// big-endian words written sequentially from address 0.
module mem_loader #(
  parameter int B = 16,
  parameter int W = 11
) (
  input  logic          clk,
  input  logic          reset,
  mem_loader_if.master  bus
);
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, DONE} state_t;

  localparam logic [16:0] CAP = 17'(1) << W;

  state_t       state, state_nx;
  logic [7:0]   cnt_hi_q, dat_hi_q;
  logic [W-1:0] idx_q, last_q;
  logic [15:0]  count;
  logic         take_start, cnt_over, wr_word;

  assign count = {cnt_hi_q, bus.rx_data};

  always_comb begin
    state_nx   = state;
    take_start = 1'b0;
    cnt_over   = 1'b0;
    wr_word    = 1'b0;
    case (state)
      IDLE:   if (bus.start) begin
                state_nx   = CNT_HI;
                take_start = 1'b1;
              end
      CNT_HI: if (bus.rx_done) state_nx = CNT_LO;
      CNT_LO: if (bus.rx_done) begin
                if (count == 16'd0)
                  state_nx = DONE;
                else if ({1'b0, count} > CAP) begin
                  state_nx = IDLE;
                  cnt_over = 1'b1;
                end else
                  state_nx = DAT_HI;
              end
      DAT_HI: if (bus.rx_done) state_nx = DAT_LO;
      DAT_LO: if (bus.rx_done) begin
                wr_word  = 1'b1;
                state_nx = (idx_q == last_q) ? DONE : DAT_HI;
              end
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wr_en  <= 1'b0;
      bus.rd_en  <= 1'b1;
      bus.addr   <= '0;
      bus.w_data <= '0;
      bus.err    <= 1'b0;
      cnt_hi_q   <= '0;
      dat_hi_q   <= '0;
      idx_q      <= '0;
      last_q     <= '0;
    end else begin
      bus.wr_en <= wr_word;
      bus.rd_en <= (state_nx == IDLE);
      if (take_start) begin
        bus.err  <= 1'b0;
        bus.addr <= '0;
        idx_q    <= '0;
      end
      if (cnt_over) bus.err <= 1'b1;
      if (state == CNT_HI && bus.rx_done) cnt_hi_q <= bus.rx_data;
      // count==2**W truncates to all-ones, i.e. the last valid index
      if (state == CNT_LO && bus.rx_done) last_q <= W'(count - 16'd1);
      if (state == DAT_HI && bus.rx_done) dat_hi_q <= bus.rx_data;
      if (wr_word) begin
        bus.w_data <= {dat_hi_q, bus.rx_data};
        bus.addr   <= idx_q;
        idx_q      <= idx_q + 1'b1;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader with a byte-counting reference model.
module tb_mem_loader;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_loader_if #(.B(16), .W(11)) bus ();

  mem_loader #(.B(16), .W(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // expected outputs for the current cycle
  logic        e_wr, e_rd, e_busy, e_done, e_err;
  logic [10:0] e_addr;
  logic [15:0] e_data;
  bit          active, fin;
  int          nb, cnt, k, dcount;
  logic [7:0]  chi, whi;
  logic [15:0] exp_mem [0:2047];
  logic [15:0] dut_mem [0:2047];
  logic [26:0] wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checker + model: compare at negedge, then advance the model on the
  // inputs the DUT will sample at the next rising edge.
  initial begin
    dcount = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0; fin = 0; nb = 0;
        e_wr = 0; e_rd = 1; e_addr = '0; e_data = '0;
        e_busy = 0; e_done = 0; e_err = 0;
      end
      chk("wr_en",  {31'd0, bus.wr_en}, {31'd0, e_wr});
      chk("rd_en",  {31'd0, bus.rd_en}, {31'd0, e_rd});
      chk("busy",   {31'd0, bus.busy},  {31'd0, e_busy});
      chk("done",   {31'd0, bus.done},  {31'd0, e_done});
      chk("err",    {31'd0, bus.err},   {31'd0, e_err});
      chk("addr",   {21'd0, bus.addr},  {21'd0, e_addr});
      chk("w_data", {16'd0, bus.w_data}, {16'd0, e_data});
      if (bus.wr_en === 1'b1) begin
        dut_mem[bus.addr] = bus.w_data;
        wq.push_back({bus.addr, bus.w_data});
      end
      if (bus.done === 1'b1) dcount++;
      if (!reset) begin
        e_wr = 0; e_done = 0;
        if (fin) begin
          fin = 0; active = 0;
        end else if (!active) begin
          if (bus.start) begin
            active = 1; nb = 0; e_err = 0; e_addr = '0;
          end
        end else if (bus.rx_done) begin
          nb++;
          if (nb == 1) chi = bus.rx_data;
          else if (nb == 2) begin
            cnt = {chi, bus.rx_data};
            if (cnt == 0) begin e_done = 1; fin = 1; end
            else if (cnt > 2048) begin e_err = 1; active = 0; end
          end else if (nb % 2 == 1) whi = bus.rx_data;
          else begin
            k = (nb - 2) / 2 - 1;
            e_wr = 1; e_addr = 11'(k); e_data = {whi, bus.rx_data};
            exp_mem[k] = e_data;
            if (k == cnt - 1) begin e_done = 1; fin = 1; end
          end
        end
        e_busy = active;
        e_rd   = !active;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [7:0] b);
    bus.rx_data = b; bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (bus.busy === 1'b0) return;
      tick();
    end
    chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_data = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] seq [];
    int n, c;
    reset = 1'b1; bus.start = 0; bus.rx_data = 0; bus.rx_done = 0;
    repeat (3) tick();
    chk("rst_rd_en", {31'd0, bus.rd_en}, 32'd1);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_addr",  {21'd0, bus.addr},  32'd0);
    reset = 1'b0;
    tick();

    // nominal three-word load
    wq.delete();
    pulse_start();
    seq = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    foreach (seq[i]) put(seq[i]);
    chk("nom_done_with_wr", {30'd0, bus.done, bus.wr_en}, 32'd3);
    tick();
    chk("nom_busy_after", {31'd0, bus.busy}, 32'd0);
    chk("nom_err", {31'd0, bus.err}, 32'd0);
    chk("nom_rd_en", {31'd0, bus.rd_en}, 32'd1);
    chk("nom_nwr", wq.size(), 32'd3);
    chk("nom_w0", {5'd0, wq[0]}, {5'd0, 11'd0, 16'h1234});
    chk("nom_w1", {5'd0, wq[1]}, {5'd0, 11'd1, 16'hABCD});
    chk("nom_w2", {5'd0, wq[2]}, {5'd0, 11'd2, 16'h0001});
    chk("nom_mem1", {16'd0, dut_mem[1]}, 32'hABCD);

    // zero count
    wq.delete();
    pulse_start();
    put(8'h00); put(8'h00);
    chk("zero_done", {31'd0, bus.done}, 32'd1);
    tick();
    chk("zero_done_once", {31'd0, bus.done}, 32'd0);
    chk("zero_busy", {31'd0, bus.busy}, 32'd0);
    chk("zero_nwr", wq.size(), 32'd0);

    // oversize header 2049
    c = dcount;
    pulse_start();
    put(8'h08); put(8'h01);
    chk("over_err", {31'd0, bus.err}, 32'd1);
    chk("over_busy", {31'd0, bus.busy}, 32'd0);
    tick(); tick();
    chk("over_nwr", wq.size(), 32'd0);
    chk("over_nodone", dcount - c, 32'd0);
    pulse_start();
    chk("over_err_clr", {31'd0, bus.err}, 32'd0);
    put(8'h00); put(8'h00); tick();

    // back-to-back strobes
    wq.delete();
    pulse_start();
    seq = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (seq[i]) put(seq[i]);
    tick();
    chk("b2b_nwr", wq.size(), 32'd2);
    chk("b2b_w0", {5'd0, wq[0]}, {5'd0, 11'd0, 16'hDEAD});
    chk("b2b_w1", {5'd0, wq[1]}, {5'd0, 11'd1, 16'hBEEF});

    // reset mid-load
    pulse_start();
    seq = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33};
    foreach (seq[i]) put(seq[i]);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", {25'd0, bus.wr_en, bus.rd_en, bus.busy, bus.done, bus.err, 2'b00},
        {25'd0, 7'b0100000});
    chk("mid_rst_addr_data", {5'd0, bus.addr, bus.w_data}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    wq.delete();
    pulse_start();
    put(8'h00); put(8'h01); put(8'h55); put(8'hAA);
    tick();
    chk("rst_reload", {5'd0, wq[wq.size()-1]}, {5'd0, 11'd0, 16'h55AA});

    // ignore rules: IDLE bytes, start+byte same cycle, start during DAT_HI
    wq.delete();
    put(8'hA5); put(8'h5A);
    bus.start = 1'b1; bus.rx_data = 8'h77; bus.rx_done = 1'b1;
    tick();
    bus.start = 1'b0; bus.rx_done = 1'b0;
    put(8'h00); put(8'h02); put(8'h01); put(8'h02);
    pulse_start();
    put(8'h03); put(8'h04);
    tick();
    chk("ign_nwr", wq.size(), 32'd2);
    chk("ign_w1", {5'd0, wq[1]}, {5'd0, 11'd1, 16'h0304});

    // randomized loads
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = $urandom_range(2049, 65535);
        default: n = $urandom_range(1, 24);
      endcase
      pulse_start();
      gap($urandom_range(0, 2));
      put(8'(n >> 8)); put(8'(n));
      if (n >= 1 && n <= 2048) begin
        for (int i = 0; i < 2 * n; i++) begin
          put(8'($urandom));
          if (i != 2 * n - 1) gap($urandom_range(0, 2));
        end
      end
      tick();
      wait_idle();
      if (n >= 1 && n <= 2048)
        for (int i = 0; i < n; i++)
          chk("rnd_mem", {16'd0, dut_mem[i]}, {16'd0, exp_mem[i]});
    end

    // full capacity, back-to-back
    wq.delete();
    pulse_start();
    put(8'h08); put(8'h00);
    for (int i = 0; i < 4096; i++) put(8'($urandom));
    tick();
    wait_idle();
    chk("full_nwr", wq.size(), 32'd2048);
    chk("full_last_addr", {21'd0, wq[2047][26:16]}, 32'd2047);
    chk("full_mem_last", {16'd0, dut_mem[2047]}, {16'd0, exp_mem[2047]});
    chk("full_mem_first", {16'd0, dut_mem[0]}, {16'd0, exp_mem[0]});
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
